// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: round-robin owner of the 128-bit memory bus for the
// icache (read refill) and dcache (refill + write-back), level-req/pulse-ack.
// Ports: clk_i, rst_ni (async, active low); i_* icache port; d_* dcache port;
// mem_* memory controller port; grant_o owner (01 I, 10 D); timeout_err_o.
// Optional macro ARB_TIMEOUT_EN: abandon a grant after TIMEOUT_CYCLES
// cycles without an acknowledge and raise sticky timeout_err_o.
module cache_bus_arbiter #(
  parameter int BUS_ADDRESS_WIDTH = 20,
  parameter int BUS_DATA_WIDTH    = 128,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [BUS_ADDRESS_WIDTH-5:0] i_addr_i,
  input  logic                         i_valid_i,
  output logic                         i_valid_o,
  output logic [BUS_DATA_WIDTH-1:0]    i_data_o,
  input  logic [BUS_ADDRESS_WIDTH-5:0] d_addr_i,
  input  logic [BUS_DATA_WIDTH-1:0]    d_data_i,
  input  logic                         d_we_i,
  input  logic                         d_valid_i,
  output logic                         d_valid_o,
  output logic [BUS_DATA_WIDTH-1:0]    d_data_o,
  output logic [BUS_ADDRESS_WIDTH-5:0] mem_addr_o,
  output logic [BUS_DATA_WIDTH-1:0]    mem_data_o,
  output logic                         mem_we_o,
  output logic                         mem_valid_o,
  input  logic [BUS_DATA_WIDTH-1:0]    mem_data_i,
  input  logic                         mem_valid_i,
  output logic [1:0]                   grant_o,
  output logic                         timeout_err_o
);

  localparam int AW = BUS_ADDRESS_WIDTH - 4;
  localparam int DW = BUS_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    TURN    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            last_d_q, last_d_d;
  logic [AW-1:0]   addr_d;
  logic [DW-1:0]   data_d;
  logic            we_d;
  logic            valid_d;
  logic            pick_d;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = 16;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tmo_q, tmo_d;
  logic            expired;

  assign expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_err_o = tmo_q;
`else
  assign timeout_err_o = 1'b0;
`endif

  // dcache wins a tie unless it owned the bus last
  assign pick_d = d_valid_i & (~i_valid_i | ~last_d_q);

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    addr_d   = mem_addr_o;
    data_d   = mem_data_o;
    we_d     = mem_we_o;
    valid_d  = mem_valid_o;
`ifdef ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d  = GRANT_D;
          last_d_d = 1'b1;
          addr_d   = d_addr_i;
          data_d   = d_data_i;
          we_d     = d_we_i;
          valid_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end else if (i_valid_i) begin
          state_d  = GRANT_I;
          last_d_d = 1'b0;
          addr_d   = i_addr_i;
          data_d   = '0;
          we_d     = 1'b0;
          valid_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      GRANT_I, GRANT_D: begin
        if (mem_valid_i) begin
          state_d = TURN;
          valid_d = 1'b0;
          we_d    = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (expired) begin
          state_d = TURN;
          valid_d = 1'b0;
          we_d    = 1'b0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      // one dead cycle lets the acked requester drop its level valid
      TURN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      mem_we_o    <= 1'b0;
      mem_valid_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      mem_addr_o  <= addr_d;
      mem_data_o  <= data_d;
      mem_we_o    <= we_d;
      mem_valid_o <= valid_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
`endif

  assign i_valid_o = mem_valid_i & (state_q == GRANT_I);
  assign d_valid_o = mem_valid_i & (state_q == GRANT_D);
  assign i_data_o  = mem_data_i;
  assign d_data_o  = mem_data_i;

  always_comb begin
    grant_o = 2'b00;
    unique case (1'b1)
      state_q == GRANT_I: grant_o = 2'b01;
      state_q == GRANT_D: grant_o = 2'b10;
      default:            grant_o = 2'b00;
    endcase
  end

endmodule

// File: doc/cache_bus_arbiter.md
Name: cache_bus_arbiter

Overview:
- Shares the single 128-bit external memory bus between the instruction cache (read-only refill) and the data cache (refill plus dirty-qword write-back/flush).
- Sits between both caches' bus ports and the memory controller.
- Uses the same level-request / single-pulse-acknowledge handshake as the cache bus ports, so each cache connects unchanged.

Parameters:
BUS_ADDRESS_WIDTH, 20, byte-address width of the memory bus; qword address is bits [BUS_ADDRESS_WIDTH-1:4]
BUS_DATA_WIDTH, 128, bus data width (one qword, fixed)
TIMEOUT_CYCLES, 255, cycles a grant may wait for an acknowledge (only with ARB_TIMEOUT_EN)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  asynchronous, active-low reset
i_addr_i  in  BUS_ADDRESS_WIDTH-4  icache qword address
i_valid_i  in  1  icache request (level, held until acknowledged)
i_valid_o  out  1  icache acknowledge pulse, data valid this cycle
i_data_o  out  128  icache read data
d_addr_i  in  BUS_ADDRESS_WIDTH-4  dcache qword address
d_data_i  in  128  dcache write-back data
d_we_i  in  1  dcache request is a write
d_valid_i  in  1  dcache request (level)
d_valid_o  out  1  dcache acknowledge pulse
d_data_o  out  128  dcache read data
mem_addr_o  out  BUS_ADDRESS_WIDTH-4  memory qword address
mem_data_o  out  128  memory write data
mem_we_o  out  1  memory write enable
mem_valid_o  out  1  memory request (level)
mem_data_i  in  128  memory read data
mem_valid_i  in  1  memory acknowledge pulse
grant_o  out  2  current owner: 00 none, 01 icache, 10 dcache
timeout_err_o  out  1  sticky timeout flag

Behaviour:
- States:
  - IDLE: no owner.
  - GRANT_I / GRANT_D: request outstanding on memory.
  - TURN: one-cycle bus turnaround.
- Reset, asynchronous on rst_ni low, immediate:
  - state IDLE; mem_valid_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0.
  - grant_o=00, timeout_err_o=0, last_owner=icache.
- IDLE transitions:
  - Only i_valid_i: go to GRANT_I.
  - Only d_valid_i: go to GRANT_D.
  - Both: grant the side that is not last_owner (round robin), so after reset dcache wins the first tie.
  - Neither: stay in IDLE.
- On entering GRANT_x (registered, same edge):
  - Latch the requester's address into mem_addr_o.
  - Latch data/we into mem_data_o/mem_we_o; the icache side always forces mem_we_o=0 and mem_data_o=0.
  - Set mem_valid_o=1 and set last_owner=x.
- Latency: a request sampled in IDLE at edge N gives mem_valid_o=1 in the cycle after edge N.
- While in GRANT_x:
  - mem_* outputs are held stable.
  - Requester valid and address inputs are ignored; no abort is possible.
- Acknowledge path, combinational, zero latency:
  - x_valid_o = mem_valid_i & (state==GRANT_x).
  - i_data_o = d_data_o = mem_data_i, unconditionally.
- At the edge where mem_valid_i=1 in GRANT_x: go to TURN, mem_valid_o<=0, mem_we_o<=0.
- TURN: always go to IDLE. This gives the requester one edge to drop its valid after the acknowledge, so a stale high valid is never re-granted.
- mem_valid_i in IDLE or TURN: ignored, no acknowledge is forwarded. Covers stray or post-reset acknowledges.
- Dcache flush pattern (write acknowledge, valid low one cycle, then read re-request) re-arbitrates normally; a pending icache request may be served between the two.
- grant_o encoding: 01 in GRANT_I, 10 in GRANT_D, 00 in IDLE and TURN.
- Reset mid-grant: bus is released immediately; the requester re-requests after reset.
- Back-to-back single requester: acknowledge at edge M gives the next mem_valid_o=1 after edge M+2 (TURN, then IDLE grant).

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - An 8..16-bit wait counter clears on entering GRANT_x and increments each GRANT cycle without mem_valid_i.
  - When it reaches TIMEOUT_CYCLES: go to TURN, mem_valid_o<=0, timeout_err_o<=1 (sticky until reset), no acknowledge to the requester.
  - The requester's still-high valid is re-arbitrated in IDLE.
- When undefined: no counter; grant waits indefinitely; timeout_err_o tied 0.

Test Plan:
- Reset then d_valid_i=1, d_we_i=1, d_addr_i=16'h0012, d_data_i=128'hA5.. -> next cycle mem_valid_o=1, mem_we_o=1, mem_addr_o=16'h0012, grant_o=10; mem_valid_i pulse -> d_valid_o=1 same cycle, mem_valid_o=0 next cycle.
- i_valid_i and d_valid_i both rise together after reset -> dcache granted first, icache granted after TURN/IDLE; next simultaneous tie -> dcache (last_owner=icache).
- icache read i_addr_i=16'h0100, memory acknowledges with mem_data_i=128'h0123..CDEF -> i_valid_o=1 and i_data_o equals it in the acknowledge cycle; d_valid_o stays 0.
- mem_valid_i pulse in IDLE, and i_addr_i changed during GRANT_I -> no acknowledge forwarded; mem_addr_o unchanged.
- rst_ni low mid GRANT_D -> mem_valid_o=0 and grant_o=00 asynchronously; a memory acknowledge after reset produces no d_valid_o.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory never acknowledges -> after 8 GRANT cycles mem_valid_o=0 and timeout_err_o=1 (sticky); the held request is re-granted 2 cycles later.
